// File: rtl/sisa_pkg.sv
// Shared sCPU fetch-stage definitions: next-PC select encoding and default sizes.
package sisa_pkg;

   // Source of the next program counter value.
   typedef enum logic [1:0] {
      SEL_INC = 2'd0,   // pc + 1
      SEL_TGT = 2'd1,   // target input
      SEL_RAS = 2'd2    // top of return-address stack
   } next_sel_t;

   // Default sizes used by the sCPU top level.
   localparam int SCPU_PC_W      = 4;
   localparam int SCPU_RAS_DEPTH = 4;

endpackage : sisa_pkg

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of DEPTH x W entries.
// Push when full and pop when empty are silently ignored; the owner decides
// how to flag those cases. Push and pop in the same cycle performs the pop only.
module pc_ras #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = en & pop & ~empty;
   assign do_push = en & push & ~full & ~pop;
   assign count   = cnt;
   assign dout    = empty ? '0 : mem[IW'(cnt - CW'(1))];

   // Occupancy counter; cleared by reset, entries themselves are don't-care.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (do_pop) begin
         cnt <= cnt - CW'(1);
      end else if (do_push) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Storage write: new entry lands just above the current top.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[IW'(cnt)] <= din;
      end
   end

endmodule : pc_ras

// File: rtl/pc_unit.sv
// Registered program counter with stall, jump, conditional branches and
// call/return through an internal return-address stack with sticky error flags.
module pc_unit
   import sisa_pkg::*;
#(
   parameter int              PC_W      = 4,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             jmp,
   input  logic                             beq,
   input  logic                             bne,
   input  logic                             call,
   input  logic                             ret,
   input  logic                             equal,
   input  logic [PC_W-1:0]                  target,
   output logic [PC_W-1:0]                  pc,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
   output logic                             ras_overflow,
   output logic                             ras_underflow
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] inc;
   logic [PC_W-1:0] ras_top;
   logic [PC_W-1:0] pc_next;
   logic            ras_full;
   logic            ras_empty;
   logic            push;
   logic            pop;
   logic            set_ovf;
   logic            set_unf;
   next_sel_t       sel;

   assign inc = pc_q + PC_W'(1);
   assign pc  = pc_q;

   pc_ras #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .push  (push),
      .pop   (pop),
      .din   (inc),
      .dout  (ras_top),
      .count (ras_count),
      .full  (ras_full),
      .empty (ras_empty)
   );

   // Priority select: ret > call > jmp > taken branch > increment; only the winner has side effects.
   always_comb begin
      sel     = SEL_INC;
      push    = 1'b0;
      pop     = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (ret) begin
         if (!ras_empty) begin
            sel = SEL_RAS;
            pop = 1'b1;
         end else begin
            set_unf = 1'b1;
         end
      end else if (call) begin
         sel = SEL_TGT;
         if (!ras_full) begin
            push = 1'b1;
         end else begin
            set_ovf = 1'b1;
         end
      end else if (jmp || (beq && equal) || (bne && !equal)) begin
         sel = SEL_TGT;
      end
   end

   // Next-PC multiplexer driven by the select decision.
   always_comb begin
      pc_next = inc;
      case (sel)
         SEL_TGT: pc_next = target;
         SEL_RAS: pc_next = ras_top;
         default: pc_next = inc;
      endcase
   end

   // PC register and sticky error flags; everything holds while en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_VEC;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else if (en) begin
         pc_q          <= pc_next;
         ras_overflow  <= ras_overflow  | set_ovf;
         ras_underflow <= ras_underflow | set_unf;
      end
   end

endmodule : pc_unit
